axi_arb_out_stage: RTL
======================

Name: axi_arb_out_stage

Overview:
- Output stage of an AXI-node request arbitration tree; sits directly downstream of the root of a tree of 2:1 round-robin fan-in primitives.
- Buffers the winning request in a 2-entry skid FIFO and returns grant to the tree.
- Generates the round-robin flag vector that steers every tree level.
- Runs an exclusive-lock FSM that pins the tree to one initiator for a multi-beat locked sequence.

Parameters:
AUX_WIDTH, 32, width of the payload (address/control bundle) carried per request
ID_WIDTH, 16, width of the transaction ID
N_INIT, 4, number of initiators feeding the tree (2..16, need not be a power of two)
LOG_N, max(1,$clog2(N_INIT)), width of the round-robin flag and source index (derived)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
in_req_i  in  1  request from tree root
in_aux_i  in  AUX_WIDTH  payload from tree root
in_id_i  in  ID_WIDTH  ID from tree root
in_src_i  in  LOG_N  index of the initiator that won at the root
in_last_i  in  1  final beat of the sequence
in_excl_i  in  1  beat belongs to an exclusive/locked sequence
in_gnt_o  out  1  grant to tree root
out_valid_o  out  1  buffered request valid
out_aux_o  out  AUX_WIDTH  head payload
out_id_o  out  ID_WIDTH  head ID
out_last_o  out  1  head last flag
out_ready_i  in  1  downstream accepts head
rr_flag_o  out  LOG_N  round-robin priority vector to the tree levels
lock_excl_o  out  1  tree is locked to sel_excl_o
sel_excl_o  out  LOG_N  locked initiator index

Behaviour:
- Reset (rst_n low, asynchronous): FIFO count=0, both pointers=0, rr counter=0, FSM=IDLE, captured select=0.
- Output values during reset: in_gnt_o=1 (count<2), out_valid_o=0, rr_flag_o=0, lock_excl_o=0, sel_excl_o=0. out_aux_o/out_id_o/out_last_o are don't-care while out_valid_o=0.
- FIFO:
  - 2 entries, each {aux, id, last}.
  - in_gnt_o = (count<2); combinational from count only, never from in_req_i.
  - push = in_req_i & in_gnt_o; pop = out_valid_o & out_ready_i; out_valid_o = (count!=0).
  - Head entry drives out_*.
  - Push and pop in the same cycle at count=1: count stays 1, pointers both advance.
  - At count=2 no push is possible; a pop frees a slot for the next cycle.
  - At count=0 no pop is possible.
  - No combinational path from in_* to out_*: minimum latency 1 cycle; throughput 1 beat/cycle with out_ready_i held high.
  - out_* stay stable while out_valid_o=1 and out_ready_i=0.
- Round-robin counter:
  - Advances by 1 on a push with in_last_i=1 while FSM=IDLE, or on the push that releases LOCKED.
  - Wraps from N_INIT-1 to 0.
  - Frozen otherwise, including on non-last beats.
  - rr_flag_o = counter (registered).
- Lock FSM, states IDLE and LOCKED:
  - IDLE→LOCKED on push with in_excl_i=1 & in_last_i=0; captured select <= in_src_i.
  - A single-beat exclusive (in_excl_i=1 & in_last_i=1) stays IDLE and is treated as normal.
  - LOCKED→IDLE on push with in_last_i=1.
  - In LOCKED, in_excl_i and in_src_i are ignored.
  - lock_excl_o = (state==LOCKED); sel_excl_o = captured select. Both are registered, asserted from the cycle after the locking push, and deasserted the cycle after the releasing push.
- Reset mid-sequence discards FIFO contents and any lock immediately; no partial state survives.

Test Plan:
- Reset then idle: rst_n low with in_req_i=1 → in_gnt_o=1, out_valid_o=0, rr_flag_o=0, lock_excl_o=0; after release, first push appears on out_* the next cycle.
- Back-pressure: out_ready_i=0, push 3 single-beat requests (ID 0x11, 0x22, 0x33) → in_gnt_o drops after the 2nd push; set out_ready_i=1 → out_id_o sequence 0x11, 0x22, 0x33; 0x33 is accepted the cycle after the first pop.
- Round-robin wrap with N_INIT=3: 4 single-beat last pushes → rr_flag_o goes 1,2,0,1.
- Exclusive lock: push in_excl_i=1, in_src_i=2, last=0 → next cycle lock_excl_o=1, sel_excl_o=2, rr frozen. Two further beats, the second with last=1 → lock_excl_o=0 the cycle after, rr advances by exactly 1.
- Streaming: out_ready_i=1, in_req_i=1 for 8 cycles → 8 beats out in order, count never exceeds 1, in_gnt_o constant 1.
- Reset mid-lock: assert rst_n low while LOCKED with count=2 → lock_excl_o=0, out_valid_o=0, rr_flag_o=0 immediately.

Source files
------------

// File: rtl/axi_arb_out_stage.sv
// Output stage of the request arbitration tree: 2-entry skid FIFO, round-robin
// flag generation, and the exclusive-lock FSM that pins the tree to one initiator.
module axi_arb_out_stage #(
    parameter int AUX_WIDTH = 32,
    parameter int ID_WIDTH  = 16,
    parameter int N_INIT    = 4,
    parameter int LOG_N     = (N_INIT > 2) ? $clog2(N_INIT) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_req_i,
    input  logic [AUX_WIDTH-1:0] in_aux_i,
    input  logic [ID_WIDTH-1:0]  in_id_i,
    input  logic [LOG_N-1:0]     in_src_i,
    input  logic                 in_last_i,
    input  logic                 in_excl_i,
    output logic                 in_gnt_o,
    output logic                 out_valid_o,
    output logic [AUX_WIDTH-1:0] out_aux_o,
    output logic [ID_WIDTH-1:0]  out_id_o,
    output logic                 out_last_o,
    input  logic                 out_ready_i,
    output logic [LOG_N-1:0]     rr_flag_o,
    output logic                 lock_excl_o,
    output logic [LOG_N-1:0]     sel_excl_o
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    logic [AUX_WIDTH-1:0] aux_mem_r [2];
    logic [ID_WIDTH-1:0]  id_mem_r  [2];
    logic                 last_mem_r [2];
    logic [1:0]           count_r;
    logic [1:0]           count_nxt_s;
    logic                 wr_ptr_r;
    logic                 rd_ptr_r;
    logic                 push_s;
    logic                 pop_s;
    logic [LOG_N-1:0]     rr_r;
    logic [LOG_N-1:0]     rr_nxt_s;
    lock_state_t          state_r;
    lock_state_t          state_nxt_s;
    logic [LOG_N-1:0]     sel_r;
    logic [LOG_N-1:0]     sel_nxt_s;

    // Grant depends only on occupancy so the tree never sees a loop through in_req_i.
    assign in_gnt_o    = (count_r != 2'd2);
    assign out_valid_o = (count_r != 2'd0);
    assign push_s      = in_req_i & in_gnt_o;
    assign pop_s       = out_valid_o & out_ready_i;

    assign out_aux_o   = aux_mem_r[rd_ptr_r];
    assign out_id_o    = id_mem_r[rd_ptr_r];
    assign out_last_o  = last_mem_r[rd_ptr_r];

    assign rr_flag_o   = rr_r;
    assign lock_excl_o = (state_r == ST_LOCKED);
    assign sel_excl_o  = sel_r;

    // FIFO occupancy next-state.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                aux_mem_r[i]  <= {AUX_WIDTH{1'b0}};
                id_mem_r[i]   <= {ID_WIDTH{1'b0}};
                last_mem_r[i] <= 1'b0;
            end
            count_r  <= 2'd0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
        end else begin
            if (push_s) begin
                aux_mem_r[wr_ptr_r]  <= in_aux_i;
                id_mem_r[wr_ptr_r]   <= in_id_i;
                last_mem_r[wr_ptr_r] <= in_last_i;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_nxt_s;
        end
    end

    // Lock FSM and round-robin next-state; a last beat ends a sequence in either state.
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_r;
        rr_nxt_s    = rr_r;
        case (state_r)
            ST_IDLE: begin
                if (push_s && in_excl_i && !in_last_i) begin
                    state_nxt_s = ST_LOCKED;
                    sel_nxt_s   = in_src_i;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (push_s && in_last_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (push_s && in_last_i) begin
            if (rr_r == LOG_N'(N_INIT - 1)) begin
                rr_nxt_s = {LOG_N{1'b0}};
            end else begin
                rr_nxt_s = rr_r + LOG_N'(1);
            end
        end else begin
            rr_nxt_s = rr_r;
        end
    end

    // Lock state, captured initiator and round-robin counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            sel_r   <= {LOG_N{1'b0}};
            rr_r    <= {LOG_N{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            sel_r   <= sel_nxt_s;
            rr_r    <= rr_nxt_s;
        end
    end

endmodule
